// File: rtl/fifo_pop_stream_if.sv
// Handshake bundle for fifo_pop_stream: the upstream FIFO read side
// (pop / valid / rdata / empty) plus the downstream valid/ready stream
// and the status outputs. The master modport is the adapter's own view.
interface fifo_pop_stream_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
);
    localparam int OW = $clog2(DEPTH + 1);

    logic             fifo_empty;
    logic             fifo_pop;
    logic             fifo_valid;
    logic [WIDTH-1:0] fifo_rdata;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [OW-1:0]    occupancy;
    logic             err_unexp;

    modport master (
        input  fifo_empty, fifo_valid, fifo_rdata, out_ready,
        output fifo_pop, out_valid, out_data, occupancy, err_unexp
    );

    modport slave (
        output fifo_empty, fifo_valid, fifo_rdata, out_ready,
        input  fifo_pop, out_valid, out_data, occupancy, err_unexp
    );
endinterface

// File: rtl/fifo_pop_stream.sv
// Read-side adapter from a fixed-latency FIFO to a valid/ready stream.
// Pops are issued speculatively against a credit: stored entries plus
// responses still in flight may never exceed the skid depth (plus the slot
// being freed this cycle), so every returning word always has a home.
module fifo_pop_stream #(
    parameter int WIDTH  = 16,
    parameter int RD_LAT = 1,
    parameter int DEPTH  = 2
) (
    input  logic               clk,
    input  logic               rst,
    fifo_pop_stream_if.master  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(RD_LAT + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Wide enough that cnt + infl and DEPTH + 1 never wrap.
    localparam int SW = $clog2(DEPTH + RD_LAT + 2);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    infl_q, infl_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             deq;
    logic             enq;
    logic             pop;
    logic [SW-1:0]    used_w;
    logic [SW-1:0]    limit_w;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Handshake decode, credit check and next-state computation.
    always_comb begin
        deq      = (cnt_q != '0) && bus.out_ready;
        // A response with nothing in flight is stray and must not be stored.
        enq      = bus.fifo_valid && (infl_q != '0);
        used_w   = SW'(cnt_q) + SW'(infl_q);
        limit_w  = SW'(DEPTH) + SW'(deq);
        pop      = !rst && !bus.fifo_empty && (used_w < limit_w);
        infl_d   = infl_q + IW'(pop) - IW'(enq);
        cnt_d    = cnt_q + CW'(enq) - CW'(deq);
        wr_ptr_d = enq ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = deq ? next_ptr(rd_ptr_q) : rd_ptr_q;
        err_d    = err_q | (bus.fifo_valid && (infl_q == '0));
    end

    // Control state; reset also discards any response still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            infl_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            infl_q   <= infl_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            err_q    <= err_d;
        end
    end

    // Skid storage; when full, enq and deq hit the same slot, read-before-write.
    always_ff @(posedge clk) begin
        if (enq && !rst) begin
            mem_q[wr_ptr_q] <= bus.fifo_rdata;
        end
    end

    assign bus.fifo_pop  = pop;
    assign bus.out_valid = (cnt_q != '0);
    assign bus.out_data  = mem_q[rd_ptr_q];
    assign bus.occupancy = cnt_q;
    assign bus.err_unexp = err_q;
endmodule

// File: tb/tb_fifo_pop_stream.sv
// Randomized bench for fifo_pop_stream: a fixed-latency FIFO model feeds the
// DUT, and a queue-based model of the skid buffer predicts every output.
module tb_fifo_pop_stream;
    localparam int WIDTH  = 16;
    localparam int RD_LAT = 1;
    localparam int DEPTH  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_pop_stream_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    fifo_pop_stream #(.WIDTH(WIDTH), .RD_LAT(RD_LAT), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] src_q [$];
    logic [WIDTH-1:0] sk_q  [$];
    logic [WIDTH-1:0] got_q [$];
    int               infl_m;
    bit               err_m;
    bit               pipe_v [RD_LAT];
    logic [WIDTH-1:0] pipe_d [RD_LAT];
    int               cyc;
    int               n_pop, n_deq, first_pop, first_deq, last_deq;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_stats();
        n_pop = 0; n_deq = 0; first_pop = -1; first_deq = -1; last_deq = -1;
        got_q.delete();
    endtask

    task automatic load(input int base, input int n);
        for (int i = 0; i < n; i++) src_q.push_back(WIDTH'(base + i));
    endtask

    // emode: 0 = empty follows FIFO contents, 1 = force empty, 2 = force non-empty
    task automatic cycle(input bit r, input int emode, input bit rdy, input bit inj);
        bit exp_deq, exp_pop, pop_seen, enq_m, fv;
        @(negedge clk);
        rst            = r;
        bus.out_ready  = rdy;
        bus.fifo_empty = (emode == 1) ? 1'b1 : (emode == 2) ? 1'b0 : (src_q.size() == 0);
        fv             = pipe_v[0] || inj;
        bus.fifo_valid = fv;
        bus.fifo_rdata = pipe_v[0] ? pipe_d[0] : WIDTH'($urandom);
        #1;
        exp_deq = (sk_q.size() != 0) && rdy;
        exp_pop = !r && !bus.fifo_empty && (sk_q.size() + infl_m < DEPTH + int'(exp_deq));
        chk("fifo_pop",  32'(bus.fifo_pop),  32'(exp_pop));
        chk("occupancy", 32'(bus.occupancy), 32'(sk_q.size()));
        chk("out_valid", 32'(bus.out_valid), 32'(sk_q.size() != 0));
        if (sk_q.size() != 0) chk("out_data", 32'(bus.out_data), 32'(sk_q[0]));
        chk("err_unexp", 32'(bus.err_unexp), 32'(err_m));
        pop_seen = bus.fifo_pop;
        if (pop_seen) begin
            n_pop++;
            if (first_pop < 0) first_pop = cyc;
        end
        if (exp_deq) begin
            n_deq++;
            if (first_deq < 0) first_deq = cyc;
            last_deq = cyc;
            got_q.push_back(bus.out_data);
        end
        if (r) begin
            sk_q.delete();
            src_q.delete();
            infl_m = 0;
            err_m  = 1'b0;
            for (int i = 0; i < RD_LAT; i++) pipe_v[i] = 1'b0;
        end else begin
            enq_m = fv && (infl_m != 0);
            if (exp_deq) void'(sk_q.pop_front());
            if (enq_m) sk_q.push_back(bus.fifo_rdata);
            if (fv && infl_m == 0) err_m = 1'b1;
            infl_m = infl_m + int'(pop_seen) - int'(enq_m);
            for (int i = 0; i < RD_LAT - 1; i++) begin
                pipe_v[i] = pipe_v[i+1];
                pipe_d[i] = pipe_d[i+1];
            end
            pipe_v[RD_LAT-1] = pop_seen;
            pipe_d[RD_LAT-1] = (pop_seen && src_q.size() != 0) ? src_q.pop_front()
                                                               : WIDTH'($urandom);
        end
        cyc++;
    endtask

    task automatic check_seq(input string tag, input int base, input int n);
        chk({tag, "_count"}, 32'(got_q.size()), 32'(n));
        for (int i = 0; i < n && i < got_q.size(); i++)
            chk(tag, 32'(got_q[i]), 32'(WIDTH'(base + i)));
    endtask

    initial begin
        bit allow_inj;
        rst = 1'b1; bus.fifo_empty = 1'b0; bus.fifo_valid = 1'b0;
        bus.fifo_rdata = '0; bus.out_ready = 1'b0;
        infl_m = 0; err_m = 1'b0; cyc = 0;
        for (int i = 0; i < RD_LAT; i++) begin pipe_v[i] = 1'b0; pipe_d[i] = '0; end
        clear_stats();

        // Reset held with a non-empty FIFO: no pops.
        repeat (3) cycle(1'b1, 2, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b0);
        chk("rst_pops", 32'(n_pop), 32'd0);

        // Streaming at full rate.
        clear_stats();
        load(1, 8);
        repeat (14) cycle(1'b0, 0, 1'b1, 1'b0);
        chk("stream_pops", 32'(n_pop), 32'd8);
        chk("stream_lat",  32'(first_deq - first_pop), 32'd2);
        chk("stream_span", 32'(last_deq - first_deq), 32'd7);
        check_seq("stream_data", 1, 8);

        // Back-pressure: exactly DEPTH pops, head held.
        clear_stats();
        load(1, 6);
        repeat (6) cycle(1'b0, 0, 1'b0, 1'b0);
        chk("bp_pops", 32'(n_pop), 32'(DEPTH));
        chk("bp_occ",  32'(bus.occupancy), 32'd2);
        chk("bp_head", 32'(bus.out_data), 32'h0001);
        repeat (12) cycle(1'b0, 0, 1'b1, 1'b0);
        check_seq("bp_data", 1, 6);

        // Full boundary with ready toggling every cycle.
        clear_stats();
        load(16'h0100, 10);
        repeat (4) cycle(1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 24; i++) cycle(1'b0, 0, 1'(i % 2 == 0), 1'b0);
        repeat (10) cycle(1'b0, 0, 1'b1, 1'b0);
        check_seq("full_data", 16'h0100, 10);

        // Bursty empty flag, random ready, pointer wrap.
        clear_stats();
        load(16'h0200, 5);
        repeat (24) cycle(1'b0, int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        repeat (10) cycle(1'b0, 0, 1'b1, 1'b0);
        check_seq("empty_data", 16'h0200, 5);

        // Stray response: dropped, sticky error, cleared by reset.
        clear_stats();
        repeat (3) cycle(1'b0, 0, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b1);
        repeat (4) cycle(1'b0, 0, 1'b1, 1'b0);
        chk("err_sticky", 32'(bus.err_unexp), 32'd1);
        chk("err_drop",   32'(n_deq), 32'd0);
        cycle(1'b1, 0, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b0);
        chk("err_clear", 32'(bus.err_unexp), 32'd0);

        // Reset with a pop in flight; the response arrives during reset.
        load(16'h0300, 4);
        cycle(1'b0, 0, 1'b1, 1'b0);
        clear_stats();
        cycle(1'b1, 0, 1'b1, 1'b0);
        repeat (5) cycle(1'b0, 0, 1'b1, 1'b0);
        chk("midrst_out", 32'(n_deq), 32'd0);
        chk("midrst_err", 32'(bus.err_unexp), 32'd0);

        // Random soak.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) load(int'($urandom_range(0, 65535)), int'($urandom_range(1, 3)));
            allow_inj = (infl_m == 0) && !pipe_v[0] && ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 99) == 0)
                cycle(1'b1, 0, 1'($urandom_range(0, 1)), 1'b0);
            else
                cycle(1'b0, ($urandom_range(0, 3) == 0) ? 1 : 0, 1'($urandom_range(0, 1)), allow_inj);
        end
        repeat (10) cycle(1'b0, 0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
